bank_request_arbiter: RTL and testbench
=======================================

Name: bank_request_arbiter

Overview:
Shares the 4-bank low-order-interleaved scratch memory between NR requesters. Each cycle it decodes every request's global address (bank = addr[1:0], local = addr >> 2) and arbitrates per bank with independent round-robin. It drives registered bank command ports and returns read data to the issuing requester at a fixed latency. It sits between the compute-side load/store clients and the bank SRAM macros.

Parameters:
NR, 2, number of requesters (2..8)
NB, 4, number of banks; fixed at 4 because bank select is always addr[1:0]; elaboration error otherwise
ADDR_W, 10, global address width; local address uses the same width, with the upper 2 bits zero
DATA_W, 16, data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NR  request valid, one bit per requester
req_ready  out  NR  request accepted this cycle (combinational grant)
req_we  in  NR  1 = write, 0 = read
req_addr  in  NR*ADDR_W  global address; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NR*DATA_W  write data
rsp_valid  out  NR  read data valid, one-cycle pulse
rsp_rdata  out  NR*DATA_W  read data
bank_en  out  NB  bank access strobe (registered)
bank_we  out  NB  bank write enable (registered)
bank_addr  out  NB*ADDR_W  local address (registered)
bank_wdata  out  NB*DATA_W  bank write data (registered)
bank_rdata  in  NB*DATA_W  bank read data, valid 1 cycle after bank_en
stall_cnt  out  16  saturating count of stalled requester-cycles

Behaviour:
- Reset (async assert, sync release):
  - bank_en, bank_we, rsp_valid, the response pipeline and stall_cnt are all 0.
  - bank_addr, bank_wdata and rsp_rdata are 0.
  - Every bank's RR pointer = NR-1, so requester 0 has first priority.
- Arbitration (combinational, cycle T), per bank b:
  - Candidates: all i with req_valid[i] and req_addr_i[1:0] == b.
  - Winner: the first candidate searching from ptr_b+1 upward, modulo NR.
  - req_ready[i] = 1 iff i wins its bank. req_ready never depends on itself; it may depend on req_valid and req_addr.
  - A requester with req_valid = 0 gets req_ready = 0.
- Pointer update: ptr_b <= winner only in cycles where bank b grants. It is unchanged otherwise.
- Requests to different banks in the same cycle are all granted. There is no cross-bank ordering.
- Losers hold req_valid/addr/we/wdata stable until granted. The block does not queue requests.
- Command stage, cycle T+1, for each granting bank:
  - bank_en = 1
  - bank_we = req_we of the winner
  - bank_addr = winner addr >> 2
  - bank_wdata = winner wdata
  - For non-granting banks, bank_en = 0 and bank_we = 0; addr and wdata hold their previous values.
- Read response:
  - Per bank, a 2-stage shift register carries {valid, requester id} for granted reads.
  - At the end of T+2, bank_rdata[b] is captured into rsp_rdata[id].
  - rsp_valid[id] = 1 for exactly cycle T+3. Read latency = 3 cycles from handshake.
  - Each requester receives at most one response per cycle (at most one grant per cycle), so responses are in issue order.
  - rsp_rdata holds its value after rsp_valid drops.
- Writes produce no response. They are committed by the bank at T+1.
- Read-after-write to the same address from any requester, issued in consecutive cycles, returns the new data because the bank is written at T+1 and read at T+2.
- stall_cnt: +1 per cycle for each i with req_valid & !req_ready (up to NR per cycle). Saturates at 0xFFFF; never wraps.
- Reset mid-operation: in-flight commands and responses are discarded. No rsp_valid follows reset. Pointers reinitialise.

Test Plan:
- Reset: assert rst mid-cycle with traffic -> all bank_en/rsp_valid go 0 immediately; stall_cnt = 0; after release, no stale rsp_valid appears.
- Single read: requester 0 reads addr 0x00D (bank 1, local 0x003) at T -> req_ready[0] = 1 at T; bank_en = 0010 and bank_addr[1] = 0x003 at T+1; bank_rdata[1] = 0xBEEF at T+2 -> rsp_valid[0] = 1 with rdata 0xBEEF at T+3 only.
- Conflict: requesters 0 and 1 both hold reads to bank 2 for 4 cycles -> grants alternate 0,1,0,1; stall_cnt = 4; responses arrive 3 cycles after each grant in the same order.
- Parallel: r0 reads addr 0x004 (bank 0) and r1 writes 0x5A5A to 0x007 (bank 3) in the same cycle -> both ready; bank_en = 1001 with bank_we[3] = 1 and bank_addr[3] = 0x001; rsp only for r0.
- RAW: r1 writes 0x1234 to 0x3F2, then r0 reads 0x3F2 the next cycle -> r0 receives 0x1234 at handshake+3.
- Saturation: force 70000 stalled requester-cycles -> stall_cnt = 0xFFFF and stays there.

Source files
------------

// File: rtl/bank_request_arbiter.sv
// ---------------------------------------------------------------------------
// bank_request_arbiter
//
// Shares a 4-bank, low-order-interleaved scratch memory between NR
// requesters. Each requester's global address is split into a bank select
// (addr[1:0]) and a local address (addr >> 2). Every bank runs its own
// round-robin arbiter. The winning command is registered onto the bank
// port one cycle after the handshake. Read data returns to the issuing
// requester three cycles after the handshake.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : [NR]          request valid per requester
//   req_ready    : [NR]          combinational grant (handshake this cycle)
//   req_we       : [NR]          1 = write, 0 = read
//   req_addr     : [NR*ADDR_W]   global address, requester i at i*ADDR_W
//   req_wdata    : [NR*DATA_W]   write data
//   rsp_valid    : [NR]          one-cycle read-data strobe
//   rsp_rdata    : [NR*DATA_W]   read data, holds after rsp_valid drops
//   bank_en      : [NB]          registered bank access strobe
//   bank_we      : [NB]          registered bank write enable
//   bank_addr    : [NB*ADDR_W]   registered local address
//   bank_wdata   : [NB*DATA_W]   registered write data
//   bank_rdata   : [NB*DATA_W]   bank read data, valid 1 cycle after bank_en
//   stall_cnt    : [16]          saturating count of stalled requester-cycles
// ---------------------------------------------------------------------------
module bank_request_arbiter #(
    parameter int NR     = 2,
    parameter int NB     = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR-1:0]        req_valid,
    output logic [NR-1:0]        req_ready,
    input  logic [NR-1:0]        req_we,
    input  logic [NR*ADDR_W-1:0] req_addr,
    input  logic [NR*DATA_W-1:0] req_wdata,
    output logic [NR-1:0]        rsp_valid,
    output logic [NR*DATA_W-1:0] rsp_rdata,
    output logic [NB-1:0]        bank_en,
    output logic [NB-1:0]        bank_we,
    output logic [NB*ADDR_W-1:0] bank_addr,
    output logic [NB*DATA_W-1:0] bank_wdata,
    input  logic [NB*DATA_W-1:0] bank_rdata,
    output logic [15:0]          stall_cnt
);

    localparam int IDW = (NR > 1) ? $clog2(NR) : 1;

    // Bank select is hard-wired to addr[1:0], so only 4 banks make sense.
    generate
        if (NB != 4) begin : g_bad_nb
            $error("bank_request_arbiter: NB must be 4 (bank select is addr[1:0])");
        end
        if (NR < 2 || NR > 8) begin : g_bad_nr
            $error("bank_request_arbiter: NR must be in 2..8");
        end
    endgenerate

    // Next requester index after ptr, k steps ahead, modulo NR.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NR) s = s - NR;
        return IDW'(s);
    endfunction

    // ------------------------------------------------------------------
    // Decode and per-bank round-robin arbitration (combinational)
    // ------------------------------------------------------------------
    logic [NB-1:0][IDW-1:0]    r_ptr;
    logic [NB-1:0][NR-1:0]     w_cand;
    logic [NB-1:0]             w_bank_gnt;
    logic [NB-1:0][IDW-1:0]    w_win;
    logic [NR-1:0]             w_ready;
    logic [NB-1:0]             w_win_we;
    logic [NB-1:0][ADDR_W-1:0] w_win_addr;
    logic [NB-1:0][DATA_W-1:0] w_win_wdata;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves a variable unassigned would infer a latch.
        w_cand      = '0;
        w_bank_gnt  = '0;
        w_win       = '0;
        w_ready     = '0;
        w_win_we    = '0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NR; i++) begin
                w_cand[b][i] = req_valid[i] && (req_addr[i*ADDR_W +: 2] == 2'(b));
            end
            // Search farthest-first so the nearest candidate after the
            // pointer is the last to assign, and therefore wins.
            for (int k = NR; k >= 1; k--) begin
                if (w_cand[b][rr_idx(r_ptr[b], k)]) begin
                    w_bank_gnt[b] = 1'b1;
                    w_win[b]      = rr_idx(r_ptr[b], k);
                end
            end
            if (w_bank_gnt[b]) begin
                w_ready[w_win[b]] = 1'b1;
            end
            w_win_we[b]    = req_we[w_win[b]];
            w_win_addr[b]  = req_addr[int'(w_win[b])*ADDR_W +: ADDR_W];
            w_win_wdata[b] = req_wdata[int'(w_win[b])*DATA_W +: DATA_W];
        end
    end

    assign req_ready = w_ready;

    // ------------------------------------------------------------------
    // Round-robin pointers, bank command stage and read-tag pipeline
    // ------------------------------------------------------------------
    logic [NB-1:0]             r_bank_en;
    logic [NB-1:0]             r_bank_we;
    logic [NB-1:0][ADDR_W-1:0] r_bank_addr;
    logic [NB-1:0][DATA_W-1:0] r_bank_wdata;
    logic [NB-1:0]             r_p1_v;
    logic [NB-1:0][IDW-1:0]    r_p1_id;
    logic [NB-1:0]             r_p2_v;
    logic [NB-1:0][IDW-1:0]    r_p2_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                r_ptr[b] <= IDW'(NR - 1);
            end
            r_bank_en    <= '0;
            r_bank_we    <= '0;
            r_bank_addr  <= '0;
            r_bank_wdata <= '0;
            r_p1_v       <= '0;
            r_p1_id      <= '0;
            r_p2_v       <= '0;
            r_p2_id      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            for (int b = 0; b < NB; b++) begin
                r_bank_en[b] <= w_bank_gnt[b];
                r_bank_we[b] <= w_bank_gnt[b] & w_win_we[b];
                r_p1_v[b]    <= w_bank_gnt[b] & ~w_win_we[b];
                r_p1_id[b]   <= w_win[b];
                if (w_bank_gnt[b]) begin
                    r_ptr[b]        <= w_win[b];
                    r_bank_addr[b]  <= w_win_addr[b] >> 2;
                    r_bank_wdata[b] <= w_win_wdata[b];
                end
            end
            r_p2_v  <= r_p1_v;
            r_p2_id <= r_p1_id;
        end
    end

    assign bank_en    = r_bank_en;
    assign bank_we    = r_bank_we;
    assign bank_addr  = r_bank_addr;
    assign bank_wdata = r_bank_wdata;

    // ------------------------------------------------------------------
    // Read response: bank data is on bank_rdata while the stage-2 tag is
    // valid; steer it to the tagged requester. A requester wins at most one
    // bank per cycle, so two banks never target the same requester at once.
    // ------------------------------------------------------------------
    logic [NR-1:0]             r_rsp_valid;
    logic [NR-1:0][DATA_W-1:0] r_rsp_rdata;
    logic [NR-1:0]             w_rsp_valid_nxt;
    logic [NR-1:0][DATA_W-1:0] w_rsp_rdata_nxt;

    always_comb begin
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        for (int b = 0; b < NB; b++) begin
            if (r_p2_v[b]) begin
                w_rsp_valid_nxt[r_p2_id[b]] = 1'b1;
                w_rsp_rdata_nxt[r_p2_id[b]] = bank_rdata[b*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

    // ------------------------------------------------------------------
    // Stall counter: one count per requester waiting this cycle, saturating.
    // ------------------------------------------------------------------
    logic [15:0] r_stall_cnt;
    logic [3:0]  w_stall_inc;
    logic [16:0] w_stall_sum;

    always_comb begin
        w_stall_inc = '0;
        for (int i = 0; i < NR; i++) begin
            w_stall_inc = w_stall_inc + 4'(req_valid[i] & ~w_ready[i]);
        end
        w_stall_sum = {1'b0, r_stall_cnt} + 17'(w_stall_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_sum[16]) begin
            r_stall_cnt <= 16'hFFFF;
        end else begin
            r_stall_cnt <= w_stall_sum[15:0];
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_bank_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bank_request_arbiter
//
// Self-checking bench for bank_request_arbiter (NR=2). A behavioural SRAM
// per bank answers bank commands; a reference memory indexed by global
// address supplies expected read data, which is queued at each read
// handshake and compared when rsp_valid appears three cycles later.
// ---------------------------------------------------------------------------
module tb_bank_request_arbiter;

    localparam int NR = 2;
    localparam int NB = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic               clk;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      req_we;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR-1:0]      rsp_valid;
    logic [NR*DW-1:0]   rsp_rdata;
    logic [NB-1:0]      bank_en;
    logic [NB-1:0]      bank_we;
    logic [NB*AW-1:0]   bank_addr;
    logic [NB*DW-1:0]   bank_wdata;
    logic [NB*DW-1:0]   bank_rdata;
    logic [15:0]        stall_cnt;

    bank_request_arbiter #(.NR(NR), .NB(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural bank SRAMs: read data appears one cycle after bank_en.
    logic [DW-1:0] bmem [NB][256];
    logic [DW-1:0] brd  [NB];
    logic [DW-1:0] ref_mem [1024];

    initial for (int b = 0; b < NB; b++) brd[b] = '0;

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_en[b]) begin
                if (bank_we[b]) bmem[b][bank_addr[b*AW +: 8]] <= bank_wdata[b*DW +: DW];
                else            brd[b] <= bmem[b][bank_addr[b*AW +: 8]];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = brd[b];
    end

    // Scoreboard of outstanding reads.
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb_q[$];
    logic [NR-1:0] mon_ev;
    logic [DW-1:0] mon_ed [NR];

    always @(negedge clk) begin
        mon_ev = '0;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            if (sb_q[0].due == cyc) begin
                mon_ev[sb_q[0].id] = 1'b1;
                mon_ed[sb_q[0].id] = sb_q[0].data;
            end
            void'(sb_q.pop_front());
        end
        for (int i = 0; i < NR; i++) begin
            if (rsp_valid[i] || mon_ev[i]) begin
                check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(mon_ev[i]));
                if (rsp_valid[i] && mon_ev[i])
                    check($sformatf("rsp_rdata[%0d]", i), 32'(rsp_rdata[i*DW +: DW]), 32'(mon_ed[i]));
            end
        end
    end

    // Drive one cycle of requests; record accepted writes and reads.
    task automatic drive_cycle(input logic [1:0] v, input logic [1:0] we,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               output logic [1:0] rdy);
        logic [AW-1:0] a [NR];
        logic [DW-1:0] d [NR];
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        rdy = req_ready;
        for (int i = 0; i < NR; i++) begin
            if (v[i] && rdy[i]) begin
                if (we[i]) ref_mem[a[i]] = d[i];
                else sb_q.push_back('{id: i, data: ref_mem[a[i]], due: cyc + 3});
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0]    v;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    rdy;
        logic [3:0]    en;
        logic [3:0]    bwe;
        logic [1:0]    cb;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cdata;
    } vec_t;

    vec_t       tbl [12];
    logic [1:0] rdy;
    logic       seen;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int g = 0; g < 1024; g++) begin
            ref_mem[g]       = 16'(g * 37 + 16'h0100);
            bmem[g % 4][g / 4] = 16'(g * 37 + 16'h0100);
        end
        ref_mem[10'h00D] = 16'hBEEF;
        bmem[1][3]       = 16'hBEEF;

        //           v     we    a0      a1      d0  d1        rdy   en       bwe      cb caddr   cdata
        tbl[0]  = '{2'b00, 2'b00, 10'h000, 10'h000, 0, 16'h0000, 2'b00, 4'b0000, 4'b0000, 0, 10'h000, 0};
        tbl[1]  = '{2'b11, 2'b10, 10'h004, 10'h007, 0, 16'h5A5A, 2'b11, 4'b1001, 4'b1000, 3, 10'h001, 16'h5A5A};
        tbl[2]  = '{2'b11, 2'b00, 10'h002, 10'h006, 0, 16'h0000, 2'b01, 4'b0100, 4'b0000, 2, 10'h000, 0};
        tbl[3]  = '{2'b11, 2'b00, 10'h002, 10'h006, 0, 16'h0000, 2'b10, 4'b0100, 4'b0000, 2, 10'h001, 0};
        tbl[4]  = '{2'b11, 2'b00, 10'h002, 10'h006, 0, 16'h0000, 2'b01, 4'b0100, 4'b0000, 2, 10'h000, 0};
        tbl[5]  = '{2'b11, 2'b00, 10'h002, 10'h006, 0, 16'h0000, 2'b10, 4'b0100, 4'b0000, 2, 10'h001, 0};
        tbl[6]  = '{2'b10, 2'b10, 10'h000, 10'h3F2, 0, 16'h1234, 2'b10, 4'b0100, 4'b0100, 2, 10'h0FC, 16'h1234};
        tbl[7]  = '{2'b01, 2'b00, 10'h3F2, 10'h000, 0, 16'h0000, 2'b01, 4'b0100, 4'b0000, 2, 10'h0FC, 0};
        tbl[8]  = '{2'b10, 2'b00, 10'h000, 10'h009, 0, 16'h0000, 2'b10, 4'b0010, 4'b0000, 1, 10'h002, 0};
        tbl[9]  = '{2'b11, 2'b00, 10'h001, 10'h005, 0, 16'h0000, 2'b01, 4'b0010, 4'b0000, 1, 10'h000, 0};
        tbl[10] = '{2'b10, 2'b00, 10'h000, 10'h005, 0, 16'h0000, 2'b10, 4'b0010, 4'b0000, 1, 10'h001, 0};
        tbl[11] = '{2'b00, 2'b00, 10'h000, 10'h000, 0, 16'h0000, 2'b00, 4'b0000, 4'b0000, 1, 10'h001, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset bank_en", 32'(bank_en), 0);
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset stall_cnt", 32'(stall_cnt), 0);
        check("reset bank_addr", 32'(bank_addr[31:0]), 0);
        check("reset rsp_rdata", 32'(rsp_rdata), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single read with response hold afterwards
        drive_cycle(2'b01, 2'b00, 10'h00D, 10'h000, 0, 0, rdy);
        check("single ready", 32'(rdy), 32'h1);
        check("single bank_en", 32'(bank_en), 32'b0010);
        check("single bank_addr1", 32'(bank_addr[1*AW +: AW]), 32'h003);
        repeat (4) drive_cycle(2'b00, 2'b00, 0, 0, 0, 0, rdy);
        check("single rsp_valid dropped", 32'(rsp_valid), 0);
        check("single rsp_rdata held", 32'(rsp_rdata[DW-1:0]), 32'hBEEF);

        // Table: parallel, conflict, RAW, priority rotation, address hold
        for (int n = 0; n < 12; n++) begin
            drive_cycle(tbl[n].v, tbl[n].we, tbl[n].a0, tbl[n].a1, tbl[n].d0, tbl[n].d1, rdy);
            check($sformatf("vec%0d ready", n), 32'(rdy), 32'(tbl[n].rdy));
            check($sformatf("vec%0d bank_en", n), 32'(bank_en), 32'(tbl[n].en));
            check($sformatf("vec%0d bank_we", n), 32'(bank_we), 32'(tbl[n].bwe));
            check($sformatf("vec%0d bank_addr", n), 32'(bank_addr[int'(tbl[n].cb)*AW +: AW]), 32'(tbl[n].caddr));
            if (tbl[n].bwe[tbl[n].cb])
                check($sformatf("vec%0d bank_wdata", n), 32'(bank_wdata[int'(tbl[n].cb)*DW +: DW]), 32'(tbl[n].cdata));
        end
        check("stall after table", 32'(stall_cnt), 5);

        // Saturation: both requesters write bank 0, one stalls every cycle
        drive_cycle(2'b11, 2'b11, 10'h000, 10'h004, 16'hAAAA, 16'h5555, rdy);
        check("sat first stall", 32'(stall_cnt), 6);
        repeat (65528) @(posedge clk);
        #1;
        check("sat FFFE", 32'(stall_cnt), 32'hFFFE);
        @(posedge clk);
        #1;
        check("sat FFFF", 32'(stall_cnt), 32'hFFFF);
        repeat (4465) @(posedge clk);
        #1;
        check("sat holds", 32'(stall_cnt), 32'hFFFF);
        ref_mem[10'h000] = 16'hAAAA;
        ref_mem[10'h004] = 16'h5555;
        drive_cycle(2'b00, 2'b00, 0, 0, 0, 0, rdy);
        check("sat idle", 32'(stall_cnt), 32'hFFFF);

        // Reset in the middle of traffic
        drive_cycle(2'b11, 2'b00, 10'h00A, 10'h007, 0, 0, rdy);
        check("pre-reset ready A", 32'(rdy), 32'h3);
        drive_cycle(2'b11, 2'b00, 10'h00D, 10'h000, 0, 0, rdy);
        check("pre-reset ready B", 32'(rdy), 32'h3);
        #2;
        rst = 1'b1;
        sb_q.delete();
        req_valid = '0;
        #1;
        check("midrst bank_en", 32'(bank_en), 0);
        check("midrst bank_we", 32'(bank_we), 0);
        check("midrst rsp_valid", 32'(rsp_valid), 0);
        check("midrst stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1'b1;
        end
        check("no stale rsp after reset", 32'(seen), 0);

        // Pointers reinitialised: requester 0 first again on bank 2
        drive_cycle(2'b11, 2'b00, 10'h002, 10'h006, 0, 0, rdy);
        check("post-reset priority", 32'(rdy), 32'h1);
        drive_cycle(2'b10, 2'b00, 10'h000, 10'h006, 0, 0, rdy);
        drive_cycle(2'b01, 2'b00, 10'h000, 10'h000, 0, 0, rdy);
        check("readback ready", 32'(rdy), 32'h1);
        repeat (6) drive_cycle(2'b00, 2'b00, 0, 0, 0, 0, rdy);
        check("scoreboard drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
